// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: non-pipelined fetch/issue front end with branch-resolving PC update
module inst_fetch_unit #(
  parameter int AW       = 8,
  parameter int IW       = 17,
  parameter int RESET_PC = 0,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst_out,
  output logic [AW-1:0] pc_out,
  input  logic          exec_done,
  input  logic [1:0]    bs,
  input  logic          ps,
  input  logic          zero,
  input  logic [AW-1:0] reg_a,
  input  logic [AW-1:0] branch_offset,
  input  logic          halt,
  output logic          halted,
  output logic [CW-1:0] inst_count
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, HALTED} state_t;
  state_t        state, state_nx;
  logic [AW-1:0] pc, pc_inc, pc_br, next_pc;
  logic [IW-1:0] inst_q;
  logic [CW-1:0] count_q;
  logic          halt_pend, retire, take;
  assign imem_req   = state == FETCH;
  assign imem_addr  = pc;
  assign inst_valid = state == ISSUE;
  assign inst_out   = inst_q;
  assign pc_out     = pc;
  assign halted     = state == HALTED;
  assign inst_count = count_q;
  assign retire     = state == EXEC && exec_done;
  assign pc_inc     = pc + AW'(1);
  assign pc_br      = pc_inc + branch_offset;
  assign take       = bs == 2'b11 || (bs == 2'b01 && (zero ^ ps));
  assign next_pc    = bs == 2'b10 ? reg_a : take ? pc_br : pc_inc;
  // next state: each handshake state waits on its own strobe only
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = halt ? HALTED : FETCH;
      FETCH:   state_nx = imem_ack ? ISSUE : FETCH;
      ISSUE:   state_nx = inst_ready ? EXEC : ISSUE;
      EXEC:    state_nx = exec_done ? ((halt || halt_pend) ? HALTED : FETCH) : EXEC;
      HALTED:  state_nx = halt ? HALTED : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  // state, pc, instruction register, retire counter and deferred halt request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= AW'(RESET_PC);
      inst_q    <= '0;
      count_q   <= '0;
      halt_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_ack) inst_q <= imem_rdata;
      if (retire) pc <= next_pc;
      if (retire && !(&count_q)) count_q <= count_q + CW'(1);
      if (retire) halt_pend <= 1'b0;
      else if (halt && (state == FETCH || state == ISSUE)) halt_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed plus randomized checks against a behavioural fetch model
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, inst_valid, inst_ready, exec_done, ps, zero, halt, halted;
  logic [7:0]  imem_addr, pc_out, reg_a, branch_offset;
  logic [16:0] imem_rdata, inst_out;
  logic [1:0]  bs;
  logic [15:0] inst_count;
  logic [16:0] mem [256];
  int          mpc, mcount;
  int          vectors = 0, miscompares = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out),
    .exec_done(exec_done), .bs(bs), .ps(ps), .zero(zero), .reg_a(reg_a),
    .branch_offset(branch_offset), .halt(halt), .halted(halted), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic from_idle();
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
  endtask

  // one instruction, starting at a negedge while the unit sits in FETCH
  task automatic run_instr(input int ack_dly, input int rdy_dly, input int exec_dly,
                           input logic [1:0] b, input logic p, input logic z,
                           input logic [7:0] ra, input logic [7:0] off, input bit hlt);
    int soff, hold;
    bit tk;
    for (int i = 0; i <= ack_dly; i++) begin
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(mpc));
      chk("fetch_valid", 32'(inst_valid), 32'd0);
      imem_ack   = (i == ack_dly);
      imem_rdata = (i == ack_dly) ? mem[mpc] : 17'($urandom);
      halt       = hlt && i == 0;
      inst_ready = 1'($urandom_range(0, 1));
      exec_done  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    halt = 1'b0;
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("issue_valid", 32'(inst_valid), 32'd1);
      chk("issue_inst", 32'(inst_out), 32'(mem[mpc]));
      chk("issue_pc", 32'(pc_out), 32'(mpc));
      chk("issue_req", 32'(imem_req), 32'd0);
      inst_ready = (i == rdy_dly);
      imem_ack   = 1'($urandom_range(0, 1));
      exec_done  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bs = b; ps = p; zero = z; reg_a = ra; branch_offset = off;
    for (int i = 0; i <= exec_dly; i++) begin
      chk("exec_valid", 32'(inst_valid), 32'd0);
      chk("exec_req", 32'(imem_req), 32'd0);
      chk("exec_count", 32'(inst_count), 32'(mcount));
      exec_done  = (i == exec_dly);
      imem_ack   = 1'($urandom_range(0, 1));
      inst_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    exec_done = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    soff = int'($signed(off));
    tk   = (b == 2'd3) || (b == 2'd1 && z != p);
    mpc  = (b == 2'd2) ? int'(ra) : ((mpc + 1 + (tk ? soff : 0)) & 255);
    mcount = (mcount == 65535) ? mcount : mcount + 1;
    chk("retire_count", 32'(inst_count), 32'(mcount));
    chk("retire_pc", 32'(pc_out), 32'(mpc));
    if (hlt) begin
      chk("halted", 32'(halted), 32'd1);
      chk("halted_req", 32'(imem_req), 32'd0);
      hold = $urandom_range(0, 2);
      for (int i = 0; i < hold; i++) begin
        halt = 1'b1;
        @(negedge clk);
        chk("hold_halted", 32'(halted), 32'd1);
        chk("hold_pc", 32'(pc_out), 32'(mpc));
        chk("hold_count", 32'(inst_count), 32'(mcount));
      end
      halt = 1'b0;
      @(negedge clk);
    end else begin
      chk("not_halted", 32'(halted), 32'd0);
    end
  endtask

  task automatic jump_to(input logic [7:0] t);
    run_instr(0, 0, 0, 2'b10, 1'b0, 1'b0, t, 8'h00, 1'b0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 17'($urandom);
    rst_n = 1'b0; imem_ack = 0; imem_rdata = 0; inst_ready = 0; exec_done = 0;
    bs = 0; ps = 0; zero = 0; reg_a = 0; branch_offset = 0; halt = 0;
    mpc = 0; mcount = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_inst", 32'(inst_out), 32'd0);
    chk("rst_count", 32'(inst_count), 32'd0);
    rst_n = 1'b1;
    from_idle();
    repeat (3) run_instr(0, 0, 0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("seq_count3", 32'(inst_count), 32'd3);
    jump_to(8'h05);
    run_instr(0, 0, 0, 2'b01, 1'b0, 1'b1, 8'h00, 8'hFE, 1'b0);
    chk("bz_taken", 32'(pc_out), 32'h04);
    jump_to(8'h05);
    run_instr(0, 0, 0, 2'b01, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b0);
    chk("bz_not_taken", 32'(pc_out), 32'h06);
    jump_to(8'h05);
    run_instr(0, 0, 0, 2'b01, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0);
    chk("bnz_taken", 32'(pc_out), 32'h04);
    jump_to(8'h05);
    run_instr(0, 0, 0, 2'b01, 1'b1, 1'b1, 8'h00, 8'hFE, 1'b0);
    chk("bnz_not_taken", 32'(pc_out), 32'h06);
    jump_to(8'h3C);
    chk("jmr_addr", 32'(imem_addr), 32'h3C);
    jump_to(8'hFF);
    run_instr(0, 0, 0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("wrap_pc", 32'(pc_out), 32'h00);
    jump_to(8'hFE);
    run_instr(0, 0, 0, 2'b11, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0);
    chk("jmp_wrap", 32'(pc_out), 32'h01);
    run_instr(5, 3, 2, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_instr(0, 0, 0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    run_instr(2, 1, 1, 2'b11, 1'b0, 1'b0, 8'h00, 8'h10, 1'b1);
    for (int n = 0; n < 40; n++)
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 7) == 0);
    imem_ack = 1'b1; imem_rdata = mem[mpc];
    @(negedge clk);
    imem_ack = 1'b0;
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(inst_valid), 32'd0);
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_pc", 32'(pc_out), 32'd0);
    chk("async_count", 32'(inst_count), 32'd0);
    chk("async_inst", 32'(inst_out), 32'd0);
    mpc = 0; mcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    from_idle();
    run_instr(1, 0, 0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    mpc = 0; mcount = 0;
    @(negedge clk);
    rst_n = 1'b1; halt = 1'b1;
    @(negedge clk);
    chk("idle_halt", 32'(halted), 32'd1);
    chk("idle_halt_req", 32'(imem_req), 32'd0);
    halt = 1'b0;
    @(negedge clk);
    run_instr(0, 0, 0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
